// File: rtl/writeback_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : writeback_stage_pkg
// Description : Shared control-vector layout, load opcodes and state encoding
//               for the write-back stage.
// Revision    : 1.0 - initial release
// ============================================================================
package writeback_stage_pkg;

    // Control vector layout
    localparam int CNTRL_REG_SIZE = 8;
    localparam int RWE            = 0;  // register write enable
    localparam int RDST           = 1;  // destination is rd (else rt)
    localparam int RA             = 2;  // write link address (PC + offset)
    localparam int MR             = 3;  // memory read (load)

    // Load opcodes (insn[0:5])
    localparam logic [5:0] c_op_lb  = 6'h20;
    localparam logic [5:0] c_op_lh  = 6'h21;
    localparam logic [5:0] c_op_lw  = 6'h23;
    localparam logic [5:0] c_op_lbu = 6'h24;
    localparam logic [5:0] c_op_lhu = 6'h25;

    // Stage state encoding
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_WRITE    = 2'd2
    } wb_state_t;

endpackage : writeback_stage_pkg
`default_nettype wire

// File: rtl/writeback_stage_load_align.sv
`default_nettype none
// ============================================================================
// Module      : writeback_stage_load_align
// Description : Combinational big-endian load alignment and extension, plus
//               misalignment detection for the requested access size.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_stage_load_align
    import writeback_stage_pkg::*;
(
    input  logic [0:5]  i_opcode,
    input  logic [0:1]  i_offset,     // byte address bits [30:31]
    input  logic [0:31] i_rdata,      // big-endian memory word
    output logic [0:31] o_aligned,
    output logic        o_misaligned
);

    logic [0:7]  w_byte;
    logic [0:15] w_half;

    // Big-endian byte lane select: offset 0 is the most significant byte
    always_comb begin
        w_byte = i_rdata[0:7];
        case (i_offset)
            2'd0:    w_byte = i_rdata[0:7];
            2'd1:    w_byte = i_rdata[8:15];
            2'd2:    w_byte = i_rdata[16:23];
            default: w_byte = i_rdata[24:31];
        endcase
    end

    // Halfword select uses addr[30] only; addr[31] is the misalignment bit
    assign w_half = i_offset[0] ? i_rdata[16:31] : i_rdata[0:15];

    // Extension per opcode; unknown load opcodes behave as word loads
    always_comb begin
        o_aligned    = i_rdata;
        o_misaligned = 1'b0;
        case (i_opcode)
            c_op_lb: begin
                o_aligned = {{24{w_byte[0]}}, w_byte};
            end
            c_op_lbu: begin
                o_aligned = {24'd0, w_byte};
            end
            c_op_lh: begin
                o_aligned    = {{16{w_half[0]}}, w_half};
                o_misaligned = i_offset[1];
            end
            c_op_lhu: begin
                o_aligned    = {16'd0, w_half};
                o_misaligned = i_offset[1];
            end
            default: begin
                o_aligned    = i_rdata;
                o_misaligned = |i_offset;
            end
        endcase
    end

endmodule : writeback_stage_load_align
`default_nettype wire

// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : writeback_stage
// Description : Final pipeline stage. Selects ALU / link / load data, waits on
//               a variable-latency memory response with timeout, and pulses
//               the register write enable for exactly one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter logic [31:0] LINK_OFFSET = 32'd8,
    parameter int          MEM_TIMEOUT = 16,
    parameter int          TCNT_W      = 5
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [0:31]               insn_in,
    input  logic [0:31]               alu_in,
    input  logic [0:31]               pc_in,
    input  logic [CNTRL_REG_SIZE-1:0] control_in,
    output logic                      mem_req,
    output logic [0:31]               mem_addr,
    input  logic                      mem_valid,
    input  logic [0:31]               mem_rdata,
    output logic [0:31]               writeBackData,
    output logic [4:0]                rdOut,
    output logic [4:0]                rtOut,
    output logic [CNTRL_REG_SIZE-1:0] wbControl,
    output logic                      mem_error,
    output logic                      align_error
);

    localparam logic [TCNT_W-1:0] c_tmo_last = TCNT_W'(MEM_TIMEOUT - 1);

    wb_state_t                 r_state;
    logic                      r_in_ready;
    logic                      r_mem_req;
    logic [0:31]               r_mem_addr;
    logic [0:31]               r_wb_data;
    logic [4:0]                r_rd;
    logic [4:0]                r_rt;
    logic [0:5]                r_opcode;
    logic [0:1]                r_offs;
    logic [CNTRL_REG_SIZE-1:0] r_ctrl;
    logic                      r_wb_rwe;
    logic                      r_mem_error;
    logic                      r_align_error;
    logic [TCNT_W-1:0]         r_tcnt;

    logic [0:5]  w_la_opcode;
    logic [0:1]  w_la_offset;
    logic [0:31] w_aligned;
    logic        w_misaligned;
    logic        w_unused;

    // In IDLE the aligner checks the incoming access; afterwards it formats
    // the returning data for the captured access.
    assign w_la_opcode = (r_state == ST_IDLE) ? insn_in[0:5]  : r_opcode;
    assign w_la_offset = (r_state == ST_IDLE) ? alu_in[30:31] : r_offs;

    writeback_stage_load_align u_load_align (
        .i_opcode     (w_la_opcode),
        .i_offset     (w_la_offset),
        .i_rdata      (mem_rdata),
        .o_aligned    (w_aligned),
        .o_misaligned (w_misaligned)
    );

    // Instruction fields this stage does not consume
    assign w_unused = &{1'b0, insn_in[6:10], insn_in[21:31]};

    // Stage FSM with registered handshake, capture and write-back outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_in_ready    <= 1'b1;
            r_mem_req     <= 1'b0;
            r_mem_addr    <= '0;
            r_wb_data     <= '0;
            r_rd          <= '0;
            r_rt          <= '0;
            r_opcode      <= '0;
            r_offs        <= '0;
            r_ctrl        <= '0;
            r_wb_rwe      <= 1'b0;
            r_mem_error   <= 1'b0;
            r_align_error <= 1'b0;
            r_tcnt        <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_wb_rwe <= 1'b0;
                    if (in_valid) begin
                        r_ctrl     <= control_in;
                        r_rd       <= insn_in[16:20];
                        r_rt       <= insn_in[11:15];
                        r_opcode   <= insn_in[0:5];
                        r_offs     <= alu_in[30:31];
                        r_mem_addr <= {alu_in[0:29], 2'b00};
                        r_in_ready <= 1'b0;
                        if (!control_in[MR]) begin
                            r_wb_data <= control_in[RA] ? (pc_in + LINK_OFFSET) : alu_in;
                            r_wb_rwe  <= control_in[RWE];
                            r_state   <= ST_WRITE;
                        end else if (w_misaligned) begin
                            r_align_error <= 1'b1;
                            r_wb_rwe      <= 1'b0;
                            r_state       <= ST_WRITE;
                        end else begin
                            r_tcnt    <= '0;
                            r_mem_req <= 1'b1;
                            r_state   <= ST_WAIT_MEM;
                        end
                    end
                end
                ST_WAIT_MEM: begin
                    r_tcnt <= r_tcnt + 1'b1;
                    if (mem_valid) begin
                        r_wb_data <= w_aligned;
                        r_wb_rwe  <= r_ctrl[RWE];
                        r_mem_req <= 1'b0;
                        r_state   <= ST_WRITE;
                    end else if (r_tcnt == c_tmo_last) begin
                        // Abandon the load: data is left untouched
                        r_mem_error <= 1'b1;
                        r_wb_rwe    <= 1'b0;
                        r_mem_req   <= 1'b0;
                        r_state     <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    r_wb_rwe   <= 1'b0;
                    r_in_ready <= 1'b1;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_wb_rwe   <= 1'b0;
                    r_mem_req  <= 1'b0;
                    r_in_ready <= 1'b1;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    // Captured control with the write enable gated to the WRITE cycle
    always_comb begin
        wbControl      = r_ctrl;
        wbControl[RWE] = r_wb_rwe;
    end

    assign in_ready      = r_in_ready;
    assign mem_req       = r_mem_req;
    assign mem_addr      = r_mem_addr;
    assign writeBackData = r_wb_data;
    assign rdOut         = r_rd;
    assign rtOut         = r_rt;
    assign mem_error     = r_mem_error;
    assign align_error   = r_align_error;

endmodule : writeback_stage
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_stage
// Description : Directed self-checking bench for writeback_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_stage;
    import writeback_stage_pkg::*;

    logic                      clock;
    logic                      reset;
    logic                      in_valid;
    logic                      in_ready;
    logic [31:0]               insn_in;
    logic [31:0]               alu_in;
    logic [31:0]               pc_in;
    logic [CNTRL_REG_SIZE-1:0] control_in;
    logic                      mem_req;
    logic [31:0]               mem_addr;
    logic                      mem_valid;
    logic [31:0]               mem_rdata;
    logic [31:0]               writeBackData;
    logic [4:0]                rdOut;
    logic [4:0]                rtOut;
    logic [CNTRL_REG_SIZE-1:0] wbControl;
    logic                      mem_error;
    logic                      align_error;

    int errors = 0;
    int checks = 0;

    writeback_stage dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .insn_in       (insn_in),
        .alu_in        (alu_in),
        .pc_in         (pc_in),
        .control_in    (control_in),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_valid     (mem_valid),
        .mem_rdata     (mem_rdata),
        .writeBackData (writeBackData),
        .rdOut         (rdOut),
        .rtOut         (rtOut),
        .wbControl     (wbControl),
        .mem_error     (mem_error),
        .align_error   (align_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mk_insn(input logic [5:0] op, input logic [4:0] rt, input logic [4:0] rd);
        return {op, 5'd0, rt, rd, 11'd0};
    endfunction

    function automatic logic [CNTRL_REG_SIZE-1:0] mk_ctrl(input logic rwe, input logic ra, input logic mr);
        logic [CNTRL_REG_SIZE-1:0] c;
        c       = '0;
        c[RWE]  = rwe;
        c[RDST] = 1'b1;
        c[RA]   = ra;
        c[MR]   = mr;
        return c;
    endfunction

    // Present one instruction for a single cycle (IDLE accepts it at the next posedge)
    task automatic issue(input logic [31:0] insn, input logic [31:0] alu, input logic [31:0] pc,
                         input logic [CNTRL_REG_SIZE-1:0] ctrl);
        @(negedge clock);
        in_valid   = 1'b1;
        insn_in    = insn;
        alu_in     = alu;
        pc_in      = pc;
        control_in = ctrl;
        @(negedge clock);
        in_valid   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset     = 1'b1;
        in_valid  = 1'b0;
        mem_valid = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
        checks++; if (writeBackData !== 32'h0) begin errors++; $display("FAIL rst_wbd: got %h want 0", writeBackData); end
        checks++; if ({rdOut, rtOut} !== 10'h0) begin errors++; $display("FAIL rst_rd_rt: got %h/%h want 0/0", rdOut, rtOut); end
        checks++; if (wbControl !== '0) begin errors++; $display("FAIL rst_wbctl: got %h want 0", wbControl); end
        checks++; if ({mem_error, align_error} !== 2'b00) begin errors++; $display("FAIL rst_errs: got %b want 00", {mem_error, align_error}); end
    endtask

    task automatic test_alu_write();
        issue(mk_insn(6'h00, 5'd3, 5'd5), 32'h0000_0042, 32'h0000_1000, mk_ctrl(1'b1, 1'b0, 1'b0));
        // WRITE cycle
        checks++; if (writeBackData !== 32'h0000_0042) begin errors++; $display("FAIL alu_wbd: got %h want 00000042", writeBackData); end
        checks++; if (rdOut !== 5'd5) begin errors++; $display("FAIL alu_rd: got %0d want 5", rdOut); end
        checks++; if (rtOut !== 5'd3) begin errors++; $display("FAIL alu_rt: got %0d want 3", rtOut); end
        checks++; if (wbControl[RWE] !== 1'b1) begin errors++; $display("FAIL alu_rwe_on: got %b want 1", wbControl[RWE]); end
        checks++; if (wbControl[RDST] !== 1'b1) begin errors++; $display("FAIL alu_rdst: got %b want 1", wbControl[RDST]); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL alu_busy: got %b want 0", in_ready); end
        @(negedge clock);
        // Back in IDLE: enable dropped, captured values held
        checks++; if (wbControl[RWE] !== 1'b0) begin errors++; $display("FAIL alu_rwe_off: got %b want 0", wbControl[RWE]); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL alu_ready: got %b want 1", in_ready); end
        checks++; if (rdOut !== 5'd5) begin errors++; $display("FAIL alu_rd_hold: got %0d want 5", rdOut); end
    endtask

    task automatic test_link();
        issue(mk_insn(6'h03, 5'd0, 5'd31), 32'hDEAD_BEEF, 32'h0040_0010, mk_ctrl(1'b1, 1'b1, 1'b0));
        checks++; if (writeBackData !== 32'h0040_0018) begin errors++; $display("FAIL link_wbd: got %h want 00400018", writeBackData); end
        checks++; if (wbControl[RWE] !== 1'b1) begin errors++; $display("FAIL link_rwe: got %b want 1", wbControl[RWE]); end
        @(negedge clock);
        issue(mk_insn(6'h03, 5'd0, 5'd31), 32'h1234_5678, 32'hFFFF_FFFC, mk_ctrl(1'b1, 1'b1, 1'b0));
        checks++; if (writeBackData !== 32'h0000_0004) begin errors++; $display("FAIL link_wrap: got %h want 00000004", writeBackData); end
        @(negedge clock);
    endtask

    task automatic test_back_to_back();
        @(negedge clock);
        in_valid   = 1'b1;
        insn_in    = mk_insn(6'h00, 5'd0, 5'd1);
        alu_in     = 32'h0000_0011;
        control_in = mk_ctrl(1'b1, 1'b0, 1'b0);
        @(negedge clock);
        // WRITE of A; B presented but must not be taken yet
        checks++; if (writeBackData !== 32'h0000_0011) begin errors++; $display("FAIL b2b_a_wbd: got %h want 00000011", writeBackData); end
        insn_in = mk_insn(6'h00, 5'd0, 5'd2);
        alu_in  = 32'h0000_0022;
        @(negedge clock);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b want 1", in_ready); end
        checks++; if (writeBackData !== 32'h0000_0011) begin errors++; $display("FAIL b2b_hold: got %h want 00000011", writeBackData); end
        checks++; if (wbControl[RWE] !== 1'b0) begin errors++; $display("FAIL b2b_gap_rwe: got %b want 0", wbControl[RWE]); end
        @(negedge clock);
        in_valid = 1'b0;
        checks++; if (writeBackData !== 32'h0000_0022) begin errors++; $display("FAIL b2b_b_wbd: got %h want 00000022", writeBackData); end
        checks++; if (rdOut !== 5'd2) begin errors++; $display("FAIL b2b_b_rd: got %0d want 2", rdOut); end
        checks++; if (wbControl[RWE] !== 1'b1) begin errors++; $display("FAIL b2b_b_rwe: got %b want 1", wbControl[RWE]); end
        @(negedge clock);
    endtask

    // Load with mem_valid raised in the k-th WAIT_MEM cycle (k = 0 is the first)
    task automatic do_load(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] exp,
                           input int k, input string nm);
        issue(mk_insn(op, 5'd7, 5'd9), addr, 32'h0, mk_ctrl(1'b1, 1'b0, 1'b1));
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL %s_req: got %b want 1", nm, mem_req); end
        checks++; if (mem_addr !== (addr & 32'hFFFF_FFFC)) begin errors++; $display("FAIL %s_addr: got %h want %h", nm, mem_addr, addr & 32'hFFFF_FFFC); end
        checks++; if (wbControl[RWE] !== 1'b0) begin errors++; $display("FAIL %s_wait_rwe: got %b want 0", nm, wbControl[RWE]); end
        repeat (k) @(negedge clock);
        mem_valid = 1'b1;
        @(negedge clock);
        mem_valid = 1'b0;
        checks++; if (writeBackData !== exp) begin errors++; $display("FAIL %s_wbd: got %h want %h", nm, writeBackData, exp); end
        checks++; if (wbControl[RWE] !== 1'b1) begin errors++; $display("FAIL %s_rwe: got %b want 1", nm, wbControl[RWE]); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL %s_req_off: got %b want 0", nm, mem_req); end
        @(negedge clock);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_idle: got %b want 1", nm, in_ready); end
    endtask

    task automatic test_loads();
        do_load(c_op_lw,  32'h0000_1004, 32'h80FF_7F01, 3, "lw");
        do_load(c_op_lb,  32'h0000_1000, 32'hFFFF_FF80, 3, "lb");
        do_load(c_op_lbu, 32'h0000_1001, 32'h0000_00FF, 3, "lbu");
        do_load(c_op_lhu, 32'h0000_1000, 32'h0000_80FF, 3, "lhu");
        do_load(c_op_lh,  32'h0000_1002, 32'h0000_7F01, 3, "lh");
    endtask

    task automatic test_timeout();
        issue(mk_insn(c_op_lw, 5'd7, 5'd9), 32'h0000_2000, 32'h0, mk_ctrl(1'b1, 1'b0, 1'b1));
        repeat (15) @(negedge clock);
        // Last WAIT_MEM cycle
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL tmo_last_req: got %b want 1", mem_req); end
        checks++; if (mem_error !== 1'b0) begin errors++; $display("FAIL tmo_early: got %b want 0", mem_error); end
        @(negedge clock);
        checks++; if (mem_error !== 1'b1) begin errors++; $display("FAIL tmo_err: got %b want 1", mem_error); end
        checks++; if (wbControl[RWE] !== 1'b0) begin errors++; $display("FAIL tmo_rwe: got %b want 0", wbControl[RWE]); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL tmo_req: got %b want 0", mem_req); end
        checks++; if (writeBackData !== 32'h0000_7F01) begin errors++; $display("FAIL tmo_wbd: got %h want 00007f01", writeBackData); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL tmo_write: got %b want 0", in_ready); end
        @(negedge clock);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL tmo_idle: got %b want 1", in_ready); end
        mem_valid = 1'b1;
        @(negedge clock);
        mem_valid = 1'b0;
        checks++; if (wbControl[RWE] !== 1'b0) begin errors++; $display("FAIL stray_rwe: got %b want 0", wbControl[RWE]); end
        checks++; if (writeBackData !== 32'h0000_7F01) begin errors++; $display("FAIL stray_wbd: got %h want 00007f01", writeBackData); end
        checks++; if (mem_error !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %b want 1", mem_error); end
        // mem_valid in the final allowed cycle still completes the load
        do_reset();
        do_load(c_op_lw, 32'h0000_3000, 32'h80FF_7F01, 15, "lw_last");
        checks++; if (mem_error !== 1'b0) begin errors++; $display("FAIL lw_last_err: got %b want 0", mem_error); end
    endtask

    task automatic do_misaligned(input logic [5:0] op, input logic [31:0] addr, input string nm);
        issue(mk_insn(op, 5'd7, 5'd9), addr, 32'h0, mk_ctrl(1'b1, 1'b0, 1'b1));
        checks++; if (align_error !== 1'b1) begin errors++; $display("FAIL %s_aerr: got %b want 1", nm, align_error); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL %s_req: got %b want 0", nm, mem_req); end
        checks++; if (wbControl[RWE] !== 1'b0) begin errors++; $display("FAIL %s_rwe: got %b want 0", nm, wbControl[RWE]); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL %s_write: got %b want 0", nm, in_ready); end
        @(negedge clock);
        checks++; if ({in_ready, mem_req} !== 2'b10) begin errors++; $display("FAIL %s_idle: got %b want 10", nm, {in_ready, mem_req}); end
    endtask

    task automatic test_misaligned();
        do_reset();
        checks++; if (align_error !== 1'b0) begin errors++; $display("FAIL mis_clear: got %b want 0", align_error); end
        do_misaligned(c_op_lw, 32'h0000_4002, "mis_lw");
        do_reset();
        do_misaligned(c_op_lh, 32'h0000_4001, "mis_lh");
        // Byte loads are never misaligned; immediate response
        do_load(c_op_lb, 32'h0000_4003, 32'h0000_0001, 0, "lb_odd");
    endtask

    task automatic test_reset_mid();
        issue(mk_insn(c_op_lw, 5'd7, 5'd9), 32'h0000_5000, 32'h0, mk_ctrl(1'b1, 1'b0, 1'b1));
        @(negedge clock);
        // Second WAIT_MEM cycle
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %b want 1", in_ready); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rmid_req: got %b want 0", mem_req); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rmid_addr: got %h want 0", mem_addr); end
        checks++; if (writeBackData !== 32'h0) begin errors++; $display("FAIL rmid_wbd: got %h want 0", writeBackData); end
        checks++; if (wbControl !== '0) begin errors++; $display("FAIL rmid_wbctl: got %h want 0", wbControl); end
        checks++; if ({rdOut, rtOut} !== 10'h0) begin errors++; $display("FAIL rmid_rd_rt: got %h/%h want 0/0", rdOut, rtOut); end
        checks++; if ({mem_error, align_error} !== 2'b00) begin errors++; $display("FAIL rmid_errs: got %b want 00", {mem_error, align_error}); end
        mem_valid = 1'b1;
        @(negedge clock);
        mem_valid = 1'b0;
        checks++; if (wbControl[RWE] !== 1'b0) begin errors++; $display("FAIL rmid_late_rwe: got %b want 0", wbControl[RWE]); end
        checks++; if (writeBackData !== 32'h0) begin errors++; $display("FAIL rmid_late_wbd: got %h want 0", writeBackData); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_late_ready: got %b want 1", in_ready); end
    endtask

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        insn_in    = '0;
        alu_in     = '0;
        pc_in      = '0;
        control_in = '0;
        mem_valid  = 1'b0;
        mem_rdata  = 32'h80FF_7F01;

        test_reset();
        test_alu_write();
        test_link();
        test_back_to_back();
        test_loads();
        test_timeout();
        test_misaligned();
        test_reset_mid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_writeback_stage
`default_nettype wire
